// File: rtl/border_overlay.sv
// border_overlay: loads digit border tables from RAM and draws RGB565 boxes on video.
// Define BOX_THICK_EN for 2-pixel-thick boxes; default build draws 1-pixel boxes.
module border_overlay #(
    parameter int          NUM_ROW   = 1,
    parameter int          NUM_COL   = 4,
    parameter int          DEPBIT    = 10,
    parameter logic [15:0] BOX_COLOR = 16'hF800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_vsync,
    input  logic              frame_hsync,
    input  logic              frame_de,
    input  logic [15:0]       pixel_data,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic [3:0]        num_col,
    input  logic [3:0]        num_row,
    input  logic              project_done_flag,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    output logic              post_vsync,
    output logic              post_hsync,
    output logic              post_de,
    output logic [15:0]       post_data,
    output logic              boxes_valid,
    output logic [3:0]        box_count
);
    localparam int CN  = 2 * NUM_COL;
    localparam int RN  = 2 * NUM_ROW;
    localparam int CIW = $clog2(CN);
    localparam int RIW = $clog2(RN);
    localparam logic [DEPBIT-1:0] ONE = DEPBIT'(1);

    typedef enum logic [1:0] {IDLE, FETCH_COL, FETCH_ROW, READY} state_t;

    state_t            state_q;
    logic              done_q;
    logic [3:0]        ncol_q, nrow_q, act_ncol_q, act_nrow_q;
    logic [DEPBIT-1:0] col_addr_q, row_addr_q, pend_addr_q;
    logic              pend_q;
    logic [DEPBIT-1:0] sh_col_q  [CN];
    logic [DEPBIT-1:0] sh_row_q  [RN];
    logic [DEPBIT-1:0] act_col_q [CN];
    logic [DEPBIT-1:0] act_row_q [RN];
    logic              boxes_valid_q;
    logic [3:0]        box_count_q;
    logic              post_vsync_q, post_hsync_q, post_de_q;
    logic [15:0]       post_data_q;

    logic              done_rise, vs_rise, edge_hit;
    logic [3:0]        ncol_eff, nrow_eff;
    logic [DEPBIT-1:0] col_last, row_last;
    logic [7:0]        prod;
    logic [3:0]        prod_sat;

    assign done_rise = project_done_flag & ~done_q;
    assign vs_rise   = frame_vsync & ~post_vsync_q;
    assign ncol_eff  = (num_col > 4'(NUM_COL)) ? 4'(NUM_COL) : num_col;
    assign nrow_eff  = (num_row > 4'(NUM_ROW)) ? 4'(NUM_ROW) : num_row;
    assign col_last  = DEPBIT'({ncol_q, 1'b0});
    assign row_last  = DEPBIT'({nrow_q, 1'b0});
    assign prod      = {4'b0, ncol_q} * {4'b0, nrow_q};
    assign prod_sat  = (prod > 8'd15) ? 4'd15 : prod[3:0];

    function automatic logic on_box(input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] l, input logic [10:0] r,
                                    input logic [10:0] t, input logic [10:0] b);
        logic vx, vy;
        vx = (x == l) || (x == r);
        vy = (y == t) || (y == b);
`ifdef BOX_THICK_EN
        vx = vx || (x == l + 11'd1) || (x == r - 11'd1);
        vy = vy || (y == t + 11'd1) || (y == b - 11'd1);
`endif
        return (vx && y >= t && y <= b) || (vy && x >= l && x <= r);
    endfunction

    always_comb begin
        edge_hit = 1'b0;
        for (int k = 0; k < NUM_COL; k++) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                if (4'(k) < act_ncol_q && 4'(r) < act_nrow_q &&
                    on_box(xpos, ypos,
                           11'(act_col_q[2*k]), 11'(act_col_q[2*k+1]),
                           11'(act_row_q[2*r]), 11'(act_row_q[2*r+1])))
                    edge_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            ncol_q        <= '0;
            nrow_q        <= '0;
            act_ncol_q    <= '0;
            act_nrow_q    <= '0;
            col_addr_q    <= '0;
            row_addr_q    <= '0;
            pend_addr_q   <= '0;
            pend_q        <= 1'b0;
            boxes_valid_q <= 1'b0;
            box_count_q   <= '0;
            post_vsync_q  <= 1'b0;
            post_hsync_q  <= 1'b0;
            post_de_q     <= 1'b0;
            post_data_q   <= '0;
            for (int i = 0; i < CN; i++) begin
                sh_col_q[i]  <= '0;
                act_col_q[i] <= '0;
            end
            for (int i = 0; i < RN; i++) begin
                sh_row_q[i]  <= '0;
                act_row_q[i] <= '0;
            end
        end else begin
            done_q       <= project_done_flag;
            post_vsync_q <= frame_vsync;
            post_hsync_q <= frame_hsync;
            post_de_q    <= frame_de;
            post_data_q  <= (frame_de && edge_hit) ? BOX_COLOR : pixel_data;

            // Active tables only change at frame start, so a frame never mixes box sets.
            if (vs_rise && boxes_valid_q) begin
                act_ncol_q <= ncol_q;
                act_nrow_q <= nrow_q;
                act_col_q  <= sh_col_q;
                act_row_q  <= sh_row_q;
            end

            case (state_q)
                IDLE, READY: begin
                    if (done_rise) begin
                        ncol_q        <= ncol_eff;
                        nrow_q        <= nrow_eff;
                        pend_q        <= 1'b0;
                        boxes_valid_q <= 1'b0;
                        if (ncol_eff == 4'd0 || nrow_eff == 4'd0) begin
                            state_q       <= READY;
                            boxes_valid_q <= 1'b1;
                            box_count_q   <= '0;
                        end else begin
                            state_q    <= FETCH_COL;
                            col_addr_q <= ONE;
                        end
                    end
                end
                FETCH_COL: begin
                    pend_q      <= (col_addr_q != '0);
                    pend_addr_q <= col_addr_q - ONE;
                    if (pend_q)
                        sh_col_q[pend_addr_q[CIW-1:0]] <= col_border_data_rd;
                    if (col_addr_q == col_last)
                        col_addr_q <= '0;
                    else if (col_addr_q != '0)
                        col_addr_q <= col_addr_q + ONE;
                    // Address already retired and last datum landing: move on.
                    if (pend_q && col_addr_q == '0) begin
                        state_q    <= FETCH_ROW;
                        row_addr_q <= ONE;
                        pend_q     <= 1'b0;
                    end
                end
                FETCH_ROW: begin
                    pend_q      <= (row_addr_q != '0);
                    pend_addr_q <= row_addr_q - ONE;
                    if (pend_q)
                        sh_row_q[pend_addr_q[RIW-1:0]] <= row_border_data_rd;
                    if (row_addr_q == row_last)
                        row_addr_q <= '0;
                    else if (row_addr_q != '0)
                        row_addr_q <= row_addr_q + ONE;
                    if (pend_q && row_addr_q == '0) begin
                        state_q       <= READY;
                        pend_q        <= 1'b0;
                        boxes_valid_q <= 1'b1;
                        box_count_q   <= prod_sat;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign col_border_addr_rd = col_addr_q;
    assign row_border_addr_rd = row_addr_q;
    assign post_vsync         = post_vsync_q;
    assign post_hsync         = post_hsync_q;
    assign post_de            = post_de_q;
    assign post_data          = post_data_q;
    assign boxes_valid        = boxes_valid_q;
    assign box_count          = box_count_q;
endmodule

// File: tb/tb_border_overlay.sv
// Bench for border_overlay: random tables and pixels checked against a
// behavioural box model kept in the bench.
module tb_border_overlay;
    localparam int          NUM_ROW   = 1;
    localparam int          NUM_COL   = 4;
    localparam int          DEPBIT    = 10;
    localparam logic [15:0] BOX_COLOR = 16'hF800;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_vsync, frame_hsync, frame_de;
    logic [15:0]       pixel_data;
    logic [10:0]       xpos, ypos;
    logic [3:0]        num_col, num_row;
    logic              project_done_flag;
    logic [DEPBIT-1:0] col_addr, row_addr;
    logic [DEPBIT-1:0] col_data, row_data;
    logic              post_vsync, post_hsync, post_de;
    logic [15:0]       post_data;
    logic              boxes_valid;
    logic [3:0]        box_count;

    border_overlay #(
        .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL),
        .DEPBIT(DEPBIT), .BOX_COLOR(BOX_COLOR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_vsync(frame_vsync), .frame_hsync(frame_hsync),
        .frame_de(frame_de), .pixel_data(pixel_data),
        .xpos(xpos), .ypos(ypos),
        .num_col(num_col), .num_row(num_row),
        .project_done_flag(project_done_flag),
        .col_border_addr_rd(col_addr), .row_border_addr_rd(row_addr),
        .col_border_data_rd(col_data), .row_border_data_rd(row_data),
        .post_vsync(post_vsync), .post_hsync(post_hsync),
        .post_de(post_de), .post_data(post_data),
        .boxes_valid(boxes_valid), .box_count(box_count)
    );

    always #5 clk = ~clk;

    logic [DEPBIT-1:0] col_mem [1024];
    logic [DEPBIT-1:0] row_mem [1024];

    always @(posedge clk) begin
        col_data <= col_mem[col_addr];
        row_data <= row_mem[row_addr];
    end

    int col_log[$];
    int row_log[$];

    always @(negedge clk) begin
        if (col_addr != '0) col_log.push_back(int'(col_addr));
        if (row_addr != '0) row_log.push_back(int'(row_addr));
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model: shadow and active box lists.
    int m_sh_col[2*NUM_COL];
    int m_sh_row[2*NUM_ROW];
    int m_act_col[2*NUM_COL];
    int m_act_row[2*NUM_ROW];
    int m_sh_nc = 0, m_sh_nr = 0, m_act_nc = 0, m_act_nr = 0;
    bit m_valid = 0;

    logic [15:0] exp_data;
    logic        exp_de, exp_hs;

    function automatic bit model_edge(input int x, input int y);
        for (int k = 0; k < m_act_nc; k++) begin
            for (int r = 0; r < m_act_nr; r++) begin
                int l  = m_act_col[2*k];
                int rt = m_act_col[2*k+1];
                int t  = m_act_row[2*r];
                int b  = m_act_row[2*r+1];
                bit vx = (x == l) || (x == rt);
                bit vy = (y == t) || (y == b);
`ifdef BOX_THICK_EN
                vx = vx || (x == l + 1) || (x == rt - 1);
                vy = vy || (y == t + 1) || (y == b - 1);
`endif
                if ((vx && y >= t && y <= b) || (vy && x >= l && x <= rt))
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_sh_nc = 0; m_sh_nr = 0; m_act_nc = 0; m_act_nr = 0; m_valid = 0;
        for (int i = 0; i < 2*NUM_COL; i++) begin m_sh_col[i] = 0; m_act_col[i] = 0; end
        for (int i = 0; i < 2*NUM_ROW; i++) begin m_sh_row[i] = 0; m_act_row[i] = 0; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input bit de);
        xpos        = 11'(x);
        ypos        = 11'(y);
        frame_de    = de;
        frame_hsync = 1'($urandom);
        pixel_data  = 16'($urandom);
        if (pixel_data == BOX_COLOR) pixel_data = ~pixel_data;
        exp_data = (de && model_edge(x, y)) ? BOX_COLOR : pixel_data;
        exp_de   = de;
        exp_hs   = frame_hsync;
        step();
    endtask

    task automatic gen_tables();
        for (int i = 0; i < NUM_COL; i++) begin
            int l = int'($urandom_range(0, 95));
            col_mem[2*i+1] = DEPBIT'(l);
            col_mem[2*i+2] = DEPBIT'(l + int'($urandom_range(2, 12)));
        end
        for (int i = 0; i < NUM_ROW; i++) begin
            int t = int'($urandom_range(0, 95));
            row_mem[2*i+1] = DEPBIT'(t);
            row_mem[2*i+2] = DEPBIT'(t + int'($urandom_range(2, 12)));
        end
    endtask

    task automatic pulse_done(input int nc, input int nr);
        num_col = 4'(nc);
        num_row = 4'(nr);
        m_sh_nc = (nc > NUM_COL) ? NUM_COL : nc;
        m_sh_nr = (nr > NUM_ROW) ? NUM_ROW : nr;
        if (m_sh_nc > 0 && m_sh_nr > 0) begin
            for (int i = 0; i < 2*m_sh_nc; i++) m_sh_col[i] = int'(col_mem[i+1]);
            for (int i = 0; i < 2*m_sh_nr; i++) m_sh_row[i] = int'(row_mem[i+1]);
        end
        m_valid = 0;
        col_log.delete();
        row_log.delete();
        project_done_flag = 1'b1;
        step();
        project_done_flag = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!boxes_valid && n < 200) begin
            step();
            n++;
        end
        total++;
        if (boxes_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: boxes_valid=%0b required 1", name, boxes_valid);
        end
        m_valid = 1;
    endtask

    task automatic vsync();
        frame_vsync = 1'b1;
        frame_de    = 1'b0;
        step();
        if (m_valid) begin
            m_act_nc = m_sh_nc;
            m_act_nr = m_sh_nr;
            m_act_col = m_sh_col;
            m_act_row = m_sh_row;
        end
        frame_vsync = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_vsync = 1'b1; frame_hsync = 1'b1; frame_de = 1'b1;
        pixel_data = 16'hFFFF; xpos = 11'd5; ypos = 11'd5;
        step();
        step();
        total++;
        if ({post_vsync, post_hsync, post_de} !== 3'b000 || post_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_video: vs/hs/de=%b%b%b data=%h required 000 0000",
                     post_vsync, post_hsync, post_de, post_data);
        end
        total++;
        if (boxes_valid !== 1'b0 || box_count !== 4'd0 || col_addr !== '0 || row_addr !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%b count=%0d caddr=%0d raddr=%0d required all 0",
                     boxes_valid, box_count, col_addr, row_addr);
        end
        frame_vsync = 1'b0; frame_hsync = 1'b0; frame_de = 1'b0;
        rst_n = 1'b1;
        step();
        model_clear();
    endtask

    task automatic test_fetch();
        bit ok;
        col_mem[1] = 10; col_mem[2] = 40; col_mem[3] = 60; col_mem[4] = 90;
        row_mem[1] = 20; row_mem[2] = 80;
        pulse_done(2, 1);
        wait_ready("fetch");
        ok = (col_log.size() == 4);
        for (int i = 0; i < col_log.size(); i++) if (col_log[i] != i + 1) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fetch_col_addr: %0d reads, first=%0d required 4 reads 1..4",
                     col_log.size(), (col_log.size() > 0) ? col_log[0] : -1);
        end
        ok = (row_log.size() == 2);
        for (int i = 0; i < row_log.size(); i++) if (row_log[i] != i + 1) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fetch_row_addr: %0d reads required 2 reads 1..2", row_log.size());
        end
        total++;
        if (box_count !== 4'd2) begin
            bad++;
            $display("FAIL fetch_count: box_count=%0d required 2", box_count);
        end
    endtask

    task automatic test_overlay();
        int x, y;
        bit de;
        frame_vsync = 1'b1;
        frame_de    = 1'b0;
        step();
        total++;
        if (post_vsync !== 1'b1) begin
            bad++;
            $display("FAIL overlay_vs_lag: post_vsync=%b required 1", post_vsync);
        end
        vsync();
        px(10, 50, 1);
        total++;
        if (post_data !== BOX_COLOR || post_de !== 1'b1) begin
            bad++;
            $display("FAIL overlay_10_50: data=%h de=%b required %h 1", post_data, post_de, BOX_COLOR);
        end
        px(25, 20, 1);
        total++;
        if (post_data !== BOX_COLOR) begin
            bad++;
            $display("FAIL overlay_25_20: data=%h required %h", post_data, BOX_COLOR);
        end
        px(25, 50, 1);
        total++;
        if (post_data !== pixel_data) begin
            bad++;
            $display("FAIL overlay_25_50: data=%h required %h", post_data, pixel_data);
        end
        px(50, 50, 1);
        total++;
        if (post_data !== pixel_data) begin
            bad++;
            $display("FAIL overlay_50_50: data=%h required %h", post_data, pixel_data);
        end
        px(10, 50, 0);
        total++;
        if (post_data !== pixel_data || post_de !== 1'b0) begin
            bad++;
            $display("FAIL overlay_no_de: data=%h de=%b required %h 0", post_data, post_de, pixel_data);
        end
        for (int i = 0; i < 300; i++) begin
            x  = int'($urandom_range(0, 110));
            y  = int'($urandom_range(0, 110));
            de = ($urandom_range(0, 7) != 0);
            px(x, y, de);
            total++;
            if (post_data !== exp_data || post_de !== exp_de || post_hsync !== exp_hs) begin
                bad++;
                $display("FAIL overlay_rand (%0d,%0d): data=%h de=%b hs=%b required %h %b %b",
                         x, y, post_data, post_de, post_hsync, exp_data, exp_de, exp_hs);
            end
        end
    endtask

    task automatic test_clamp();
        bit ok;
        gen_tables();
        pulse_done(9, 1);
        wait_ready("clamp");
        ok = (col_log.size() == 8);
        for (int i = 0; i < col_log.size(); i++) if (col_log[i] != i + 1) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL clamp_col_reads: %0d reads required 8 reads 1..8", col_log.size());
        end
        total++;
        if (box_count !== 4'd4) begin
            bad++;
            $display("FAIL clamp_count: box_count=%0d required 4", box_count);
        end
        vsync();
        for (int i = 0; i < 200; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== exp_data) begin
                bad++;
                $display("FAIL clamp_pix (%0d,%0d): data=%h required %h", x, y, post_data, exp_data);
            end
        end
    endtask

    task automatic test_tearing();
        int n = 0;
        gen_tables();
        pulse_done(3, 1);
        total++;
        if (boxes_valid !== 1'b0) begin
            bad++;
            $display("FAIL tear_clear_valid: boxes_valid=%b required 0", boxes_valid);
        end
        while (!boxes_valid && n < 200) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            n++;
            total++;
            if (post_data !== exp_data) begin
                bad++;
                $display("FAIL tear_old_fetch (%0d,%0d): data=%h required %h", x, y, post_data, exp_data);
            end
        end
        wait_ready("tear");
        total++;
        if (box_count !== 4'd3) begin
            bad++;
            $display("FAIL tear_count: box_count=%0d required 3", box_count);
        end
        for (int i = 0; i < 100; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== exp_data) begin
                bad++;
                $display("FAIL tear_old_ready (%0d,%0d): data=%h required %h", x, y, post_data, exp_data);
            end
        end
        vsync();
        for (int i = 0; i < 200; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== exp_data) begin
                bad++;
                $display("FAIL tear_new (%0d,%0d): data=%h required %h", x, y, post_data, exp_data);
            end
        end
    endtask

    task automatic test_zero();
        gen_tables();
        pulse_done(3, 0);
        wait_ready("zero");
        for (int i = 0; i < 10; i++) step();
        total++;
        if (col_log.size() != 0 || row_log.size() != 0 || box_count !== 4'd0) begin
            bad++;
            $display("FAIL zero_skip: col_reads=%0d row_reads=%0d count=%0d required 0 0 0",
                     col_log.size(), row_log.size(), box_count);
        end
        vsync();
        for (int i = 0; i < 150; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== pixel_data || post_hsync !== exp_hs) begin
                bad++;
                $display("FAIL zero_pass (%0d,%0d): data=%h hs=%b required %h %b",
                         x, y, post_data, post_hsync, pixel_data, exp_hs);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nz = 0;
        gen_tables();
        pulse_done(4, 1);
        step();
        total++;
        if (col_addr == '0) begin
            bad++;
            $display("FAIL rstmid_in_fetch: col_addr=%0d required nonzero", col_addr);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (boxes_valid !== 1'b0 || col_addr !== '0 || row_addr !== '0) begin
            bad++;
            $display("FAIL rstmid_state: valid=%b caddr=%0d raddr=%0d required 0 0 0",
                     boxes_valid, col_addr, row_addr);
        end
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 20; i++) begin
            step();
            if (col_addr != '0 || row_addr != '0 || boxes_valid) nz++;
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL rstmid_idle: %0d active cycles required 0", nz);
        end
        vsync();
        for (int i = 0; i < 100; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== pixel_data) begin
                bad++;
                $display("FAIL rstmid_pass (%0d,%0d): data=%h required %h", x, y, post_data, pixel_data);
            end
        end
        pulse_done(2, 1);
        wait_ready("rstmid");
        vsync();
        for (int i = 0; i < 150; i++) begin
            int x = int'($urandom_range(0, 110));
            int y = int'($urandom_range(0, 110));
            px(x, y, 1);
            total++;
            if (post_data !== exp_data) begin
                bad++;
                $display("FAIL rstmid_new (%0d,%0d): data=%h required %h", x, y, post_data, exp_data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            col_mem[i] = '0;
            row_mem[i] = '0;
        end
        rst_n = 1'b0;
        frame_vsync = 1'b0; frame_hsync = 1'b0; frame_de = 1'b0;
        pixel_data = '0; xpos = '0; ypos = '0;
        num_col = '0; num_row = '0; project_done_flag = 1'b0;
        test_reset();
        test_fetch();
        test_overlay();
        test_clamp();
        test_tearing();
        test_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
